// File: rtl/wrd_ctrl.sv
// Inference sequencer for the wrd accelerator: gates feature frames in, waits for the
// wake decision under a watchdog, arbitrates cfg memory access between frames.
module wrd_ctrl #(
    parameter int DATA_BW        = 104,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int WAKE_HOLD      = 16000,
    parameter int CNT_BW         = 16
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               en_i,
    input  logic [DATA_BW-1:0] s_data_i,
    input  logic               s_valid_i,
    input  logic               s_last_i,
    output logic               s_ready_o,
    output logic [DATA_BW-1:0] m_data_o,
    output logic               m_valid_o,
    output logic               m_last_o,
    input  logic               m_ready_i,
    input  logic               wake_valid_i,
    input  logic               wake_i,
    input  logic               cfg_req_i,
    output logic               cfg_gnt_o,
    output logic               wake_o,
    output logic               busy_o,
    output logic [CNT_BW-1:0]  frame_cnt_o,
    output logic [CNT_BW-1:0]  wake_cnt_o,
    output logic [CNT_BW-1:0]  timeout_cnt_o
);

    localparam int WD_BW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int WK_BW = $clog2(WAKE_HOLD + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_WAIT
    } state_t;

    state_t            state, state_nxt;
    logic              pass, grant, decide, expire;
    logic [WD_BW-1:0]  wd_cnt;
    logic [WK_BW-1:0]  wake_tmr;
    logic [CNT_BW-1:0] frame_cnt, wake_cnt, timeout_cnt;

    function automatic logic [CNT_BW-1:0] sat_inc(input logic [CNT_BW-1:0] v);
        return (v == '1) ? v : v + CNT_BW'(1);
    endfunction

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_nxt = state;
        pass      = 1'b0;
        grant     = 1'b0;
        decide    = 1'b0;
        expire    = 1'b0;
        unique case (state)
            S_IDLE: begin
                // cfg wins over a simultaneous beat; while disabled cfg is always granted
                grant = cfg_req_i;
                pass  = en_i & ~cfg_req_i;
                if (pass & s_valid_i & m_ready_i) begin
                    state_nxt = s_last_i ? S_WAIT : S_STREAM;
                end
            end
            S_STREAM: begin
                pass = 1'b1;
                if (s_valid_i & m_ready_i & s_last_i) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wake_valid_i) begin
                    decide    = 1'b1;
                    state_nxt = S_IDLE;
                end else if (wd_cnt == '0) begin
                    expire    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Watchdog counts down the remaining wait budget; zero in WAIT means expiry this cycle
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wd_cnt <= '0;
        end else if (state_nxt == S_WAIT && state != S_WAIT) begin
            wd_cnt <= WD_BW'(TIMEOUT_CYCLES - 1);
        end else if (state == S_WAIT && wd_cnt != '0) begin
            wd_cnt <= wd_cnt - WD_BW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wake_tmr <= '0;
        end else if (decide && wake_i) begin
            wake_tmr <= WK_BW'(WAKE_HOLD);
        end else if (wake_tmr != '0) begin
            wake_tmr <= wake_tmr - WK_BW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            frame_cnt   <= '0;
            wake_cnt    <= '0;
            timeout_cnt <= '0;
        end else begin
            if (decide)           frame_cnt   <= sat_inc(frame_cnt);
            if (decide && wake_i) wake_cnt    <= sat_inc(wake_cnt);
            if (expire)           timeout_cnt <= sat_inc(timeout_cnt);
        end
    end

    // The combinational paths are masked by reset so every output reads 0 while it is held
    assign s_ready_o     = rst_n_i & m_ready_i & pass;
    assign m_valid_o     = rst_n_i & s_valid_i & pass;
    assign m_data_o      = rst_n_i ? s_data_i : '0;
    assign m_last_o      = rst_n_i & s_last_i;
    assign cfg_gnt_o     = rst_n_i & grant;
    assign busy_o        = (state == S_STREAM) || (state == S_WAIT);
    assign wake_o        = (wake_tmr != '0);
    assign frame_cnt_o   = frame_cnt;
    assign wake_cnt_o    = wake_cnt;
    assign timeout_cnt_o = timeout_cnt;

endmodule

// File: tb/tb_wrd_ctrl.sv
// Randomized scoreboard bench for wrd_ctrl: beats and frame outcomes are queued by the
// driver and compared by an independent negedge monitor.
`timescale 1ns/1ps
module tb_wrd_ctrl;

    localparam int DATA_BW = 104;
    localparam int T       = 8;
    localparam int H       = 10;
    localparam int CNT_BW  = 4;
    localparam int CMAX    = (1 << CNT_BW) - 1;

    typedef enum {P_IDLE, P_STREAM, P_WAIT} phase_t;
    typedef struct {
        logic [DATA_BW-1:0] data;
        logic               last;
    } beat_t;
    typedef struct {
        int f;
        int w;
        int t;
    } cnt_t;

    logic               clk_i, rst_n_i, en_i;
    logic [DATA_BW-1:0] s_data_i;
    logic               s_valid_i, s_last_i, s_ready_o;
    logic [DATA_BW-1:0] m_data_o;
    logic               m_valid_o, m_last_o, m_ready_i;
    logic               wake_valid_i, wake_i, cfg_req_i, cfg_gnt_o, wake_o, busy_o;
    logic [CNT_BW-1:0]  frame_cnt_o, wake_cnt_o, timeout_cnt_o;

    wrd_ctrl #(
        .DATA_BW(DATA_BW), .TIMEOUT_CYCLES(T), .WAKE_HOLD(H), .CNT_BW(CNT_BW)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i),
        .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_last_i(s_last_i), .s_ready_o(s_ready_o),
        .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_last_o(m_last_o), .m_ready_i(m_ready_i),
        .wake_valid_i(wake_valid_i), .wake_i(wake_i),
        .cfg_req_i(cfg_req_i), .cfg_gnt_o(cfg_gnt_o), .wake_o(wake_o), .busy_o(busy_o),
        .frame_cnt_o(frame_cnt_o), .wake_cnt_o(wake_cnt_o), .timeout_cnt_o(timeout_cnt_o)
    );

    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    bit     mon_en = 0;
    bit     rand_ready = 0;
    phase_t phase = P_IDLE;
    int     exp_f = 0, exp_w = 0, exp_t = 0;
    int     last_pos = -1000, prev_pos = -1000;
    beat_t  beat_q[$];
    cnt_t   cnt_q[$];

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            m_ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL sim_time_limit: got no end of stimulus, expected finish before 1 ms");
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    function automatic bit in_win(input int p, input int c);
        return (c > p) && (c <= p + H);
    endfunction

    task automatic push_counts();
        cnt_t c;
        c.f = exp_f;
        c.w = exp_w;
        c.t = exp_t;
        cnt_q.push_back(c);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_s_ready"}, s_ready_o, 0);
        check({tag, "_m_valid"}, m_valid_o, 0);
        check({tag, "_m_data"}, m_data_o, 0);
        check({tag, "_m_last"}, m_last_o, 0);
        check({tag, "_cfg_gnt"}, cfg_gnt_o, 0);
        check({tag, "_wake"}, wake_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_frame_cnt"}, frame_cnt_o, 0);
        check({tag, "_wake_cnt"}, wake_cnt_o, 0);
        check({tag, "_timeout_cnt"}, timeout_cnt_o, 0);
    endtask

    // Monitor: per-cycle handshake/grant/wake rules plus scoreboard pops
    initial begin
        bit    prev_busy;
        bit    exp_pass;
        beat_t eb;
        cnt_t  ec;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!mon_en) begin
                prev_busy = 1'b0;
            end else begin
                exp_pass = (phase == P_STREAM) || (phase == P_IDLE && en_i && !cfg_req_i);
                check("s_ready", s_ready_o, m_ready_i && exp_pass);
                check("m_valid", m_valid_o, s_valid_i && exp_pass);
                check("cfg_gnt", cfg_gnt_o, (phase == P_IDLE) && cfg_req_i);
                check("busy", busy_o, phase != P_IDLE);
                check("wake", wake_o, in_win(last_pos, cyc) || in_win(prev_pos, cyc));
                if (m_valid_o && m_ready_i) begin
                    if (beat_q.size() == 0) begin
                        check("unexpected_beat", m_valid_o, 1'b0);
                    end else begin
                        eb = beat_q.pop_front();
                        check("m_data", m_data_o, eb.data);
                        check("m_last", m_last_o, eb.last);
                    end
                end
                if (prev_busy && !busy_o) begin
                    if (cnt_q.size() == 0) begin
                        check("unexpected_frame_end", busy_o, 1'b1);
                    end else begin
                        ec = cnt_q.pop_front();
                        check("frame_cnt", frame_cnt_o, ec.f);
                        check("wake_cnt", wake_cnt_o, ec.w);
                        check("timeout_cnt", timeout_cnt_o, ec.t);
                    end
                end
                prev_busy = busy_o;
            end
        end
    end

    task automatic do_mid_reset();
        m_ready_i = 1'b1;
        cfg_req_i = 1'b1;
        s_last_i  = 1'b1;
        #2;
        mon_en  = 0;
        rst_n_i = 1'b0;
        #1;
        check_zero("mid_reset");
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
        cfg_req_i = 1'b0;
        en_i      = 1'b1;
        beat_q.delete();
        cnt_q.delete();
        exp_f = 0; exp_w = 0; exp_t = 0;
        last_pos = -1000; prev_pos = -1000;
        phase = P_IDLE;
        repeat (2) @(posedge clk_i);
        #3 rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        mon_en = 1;
    endtask

    // Driver: issues one frame, then a decision k cycles into WAIT (k >= T means timeout)
    task automatic send_frame(input int nbeats, input int cfg_pre, input int cfg_mid,
                              input int k, input bit dec, input bit en_drop, input int abort_at);
        int           pre_left, guard;
        bit           mid_cfg, acc;
        logic [127:0] r;
        beat_t        bt;
        pre_left  = cfg_pre;
        mid_cfg   = 0;
        cfg_req_i = (cfg_pre > 0);
        for (int b = 0; b < nbeats; b++) begin
            r = {$urandom(), $urandom(), $urandom(), $urandom()};
            s_data_i  = r[DATA_BW-1:0];
            s_last_i  = (b == nbeats - 1);
            s_valid_i = 1'b1;
            if (b == cfg_mid && b > 0) begin
                cfg_req_i = 1'b1;
                mid_cfg   = 1;
            end
            if (b == abort_at) begin
                do_mid_reset();
                return;
            end
            bt.data = s_data_i;
            bt.last = s_last_i;
            beat_q.push_back(bt);
            acc   = 0;
            guard = 0;
            while (!acc && guard < 200) begin
                @(negedge clk_i);
                acc = s_ready_o;
                @(posedge clk_i);
                #1;
                guard++;
                if (pre_left > 0) begin
                    pre_left--;
                    if (pre_left == 0) cfg_req_i = 1'b0;
                end
            end
            check("beat_accept", acc, 1'b1);
            if (!acc) begin
                s_valid_i = 1'b0;
                return;
            end
            phase = s_last_i ? P_WAIT : P_STREAM;
            if (b == 0 && en_drop) en_i = 1'b0;
        end
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
        if (k < T) begin
            repeat (k) begin
                @(posedge clk_i);
                #1;
                wake_i = 1'($urandom());
            end
            wake_valid_i = 1'b1;
            wake_i       = dec;
            exp_f = sat(exp_f + 1);
            if (dec) begin
                exp_w    = sat(exp_w + 1);
                prev_pos = last_pos;
                last_pos = cyc;
            end
            push_counts();
            @(posedge clk_i);
            #1;
            wake_valid_i = 1'b0;
            phase        = P_IDLE;
            en_i         = 1'b1;
        end else begin
            repeat (T) begin
                @(posedge clk_i);
                #1;
            end
            phase = P_IDLE;
            en_i  = 1'b1;
            exp_t = sat(exp_t + 1);
            push_counts();
            repeat (k - T) begin
                @(posedge clk_i);
                #1;
            end
            // a decision arriving after the watchdog fired must be ignored
            wake_valid_i = 1'b1;
            wake_i       = 1'b1;
            @(posedge clk_i);
            #1;
            wake_valid_i = 1'b0;
        end
        if (mid_cfg) begin
            @(posedge clk_i);
            #1;
            cfg_req_i = 1'b0;
        end
    endtask

    initial begin
        logic [127:0] r;
        int           nb;
        rst_n_i      = 1'b0;
        r            = {$urandom(), $urandom(), $urandom(), $urandom()};
        s_data_i     = r[DATA_BW-1:0];
        en_i         = 1'b1;
        s_valid_i    = 1'b1;
        s_last_i     = 1'b1;
        m_ready_i    = 1'b1;
        cfg_req_i    = 1'b1;
        wake_valid_i = 1'b1;
        wake_i       = 1'b1;
        #3;
        check_zero("reset");
        #20;
        s_valid_i    = 1'b0;
        s_last_i     = 1'b0;
        cfg_req_i    = 1'b0;
        wake_valid_i = 1'b0;
        wake_i       = 1'b0;
        @(posedge clk_i);
        #3 rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        mon_en = 1;

        // Directed frames with m_ready held high
        send_frame(4, 0, -1, 2, 1, 0, -1);
        repeat (12) begin @(posedge clk_i); #1; end
        send_frame(2, 3, -1, 1, 0, 0, -1);
        send_frame(5, 0, 1, 3, 0, 0, -1);
        send_frame(3, 0, -1, 9, 0, 0, -1);
        send_frame(1, 0, -1, 0, 1, 0, -1);
        send_frame(1, 0, -1, 3, 1, 0, -1);
        repeat (16) begin @(posedge clk_i); #1; end

        // Randomized frames with backpressure
        rand_ready = 1;
        for (int i = 0; i < 40; i++) begin
            nb = $urandom_range(1, 6);
            send_frame(nb, $urandom_range(0, 3),
                       ($urandom_range(0, 1) != 0) ? $urandom_range(1, 5) : -1,
                       $urandom_range(0, 11), 1'($urandom()), 1'($urandom()), -1);
            repeat ($urandom_range(0, 3)) begin @(posedge clk_i); #1; end
        end

        // Drive the timeout counter into saturation
        for (int i = 0; i < 16; i++) begin
            send_frame($urandom_range(1, 3), 0, -1, T, 0, 0, -1);
        end

        // Disabled controller: no beats pass, cfg granted on request, decisions ignored
        en_i      = 1'b0;
        s_valid_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cfg_req_i    = 1'($urandom());
            s_last_i     = 1'($urandom());
            wake_valid_i = (i == 5);
            wake_i       = 1'b1;
            @(posedge clk_i);
            #1;
        end
        s_valid_i    = 1'b0;
        s_last_i     = 1'b0;
        cfg_req_i    = 1'b0;
        wake_valid_i = 1'b0;
        en_i         = 1'b1;

        // Reset mid-stream, then frames must count from zero again
        send_frame(5, 0, -1, 0, 0, 0, 2);
        for (int i = 0; i < 3; i++) begin
            send_frame($urandom_range(1, 4), 0, -1, $urandom_range(0, 9), 1'($urandom()), 0, -1);
        end
        repeat (15) begin @(posedge clk_i); #1; end

        check("beats_left", beat_q.size(), 0);
        check("frames_left", cnt_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wrd_ctrl.md
Name: wrd_ctrl

Overview:
- Inference sequencer between the streaming feature input and the wrd accelerator. Owns the wrd weight/bias memory ports' access window.
- Gates frames into wrd and waits for each wake decision, with a watchdog on that wait.
- Grants cfg memory accesses only between frames, so weights never change mid-inference.
- Stretches the wake decision into a fixed-width wake pulse and keeps frame/wake/error counters for software.

Parameters:
- DATA_BW, 104, width of one streaming feature vector (matches the conv1 vector width).
- TIMEOUT_CYCLES, 4096, maximum cycles from the accepted last beat to wake_valid_i; must be ≥ 2.
- WAKE_HOLD, 16000, cycles wake_o stays high per positive decision (1 ms at 16 MHz); must be ≥ 1.
- CNT_BW, 16, width of the frame, wake and error counters.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- en_i  in  1  controller enable (cfg register bit)
- s_data_i  in  DATA_BW  upstream feature vector
- s_valid_i  in  1  upstream beat valid
- s_last_i  in  1  upstream last beat of frame
- s_ready_o  out  1  upstream ready
- m_data_o  out  DATA_BW  to wrd data_i
- m_valid_o  out  1  to wrd valid_i
- m_last_o  out  1  to wrd last_i
- m_ready_i  in  1  from wrd ready_o
- wake_valid_i  in  1  wrd decision strobe (single cycle)
- wake_i  in  1  wrd decision value, qualified by wake_valid_i
- cfg_req_i  in  1  cfg requests the memory ports (OR of cfg rd/wr enables)
- cfg_gnt_o  out  1  cfg may drive memory rd/wr enables
- wake_o  out  1  stretched wake pulse
- busy_o  out  1  frame in flight (STREAM or WAIT)
- frame_cnt_o  out  CNT_BW  completed frames
- wake_cnt_o  out  CNT_BW  positive decisions
- timeout_cnt_o  out  CNT_BW  watchdog expiries

Behaviour:
- Reset (asynchronous, any state): FSM enters IDLE. All counters, the wake timer and the watchdog timer clear. Every output is 0.
- Data path:
  - m_data_o = s_data_i and m_last_o = s_last_i, both combinational.
  - m_valid_o = s_valid_i & pass. s_ready_o = m_ready_i & pass.
  - pass = 1 only in STREAM, or in IDLE when not granting cfg.
  - A beat is accepted when s_valid_i & s_ready_o.
- IDLE:
  - en_i=0: pass=0 and cfg_gnt_o = cfg_req_i (cfg always allowed while disabled).
  - en_i=1 and cfg_req_i=1 (checked first): cfg_gnt_o=1, pass=0. cfg wins over a simultaneous s_valid_i.
  - en_i=1, cfg_req_i=0, a beat is accepted: go to STREAM. If that beat has last, go directly to WAIT.
- STREAM:
  - cfg_gnt_o=0 regardless of cfg_req_i; the request stays pending until IDLE.
  - An accepted beat with s_last_i=1 moves to WAIT.
  - en_i deassertion is ignored until the frame completes.
- WAIT:
  - pass=0, cfg_gnt_o=0. The watchdog loads TIMEOUT_CYCLES-1 on entry and decrements each cycle.
  - wake_valid_i=1: frame_cnt_o increments; if wake_i=1, wake_cnt_o also increments and the wake timer loads WAKE_HOLD. Then go to IDLE.
  - Watchdog reaches 0 with no wake_valid_i: timeout_cnt_o increments, frame_cnt_o does not, go to IDLE.
  - wake_valid_i in the same cycle as watchdog expiry is treated as a valid decision; no timeout is counted.
  - wake_valid_i outside WAIT is ignored: no counting, no wake.
- busy_o = 1 in STREAM or WAIT.
- Wake timer:
  - wake_o = (timer != 0); the timer decrements to 0.
  - A new positive decision while wake_o is high reloads WAKE_HOLD (retrigger, no gap).
  - wake_o rises the cycle after the wake_valid_i edge.
- Counters saturate at all-ones and never wrap.
- Grant timing:
  - cfg_gnt_o is combinational from state and cfg_req_i.
  - A grant in IDLE keeps the FSM in IDLE until cfg_req_i drops. Streaming resumes the same cycle cfg_req_i=0.

Test Plan:
- Reset, then en_i=1 and a 4-beat frame with m_ready_i=1 and last on beat 4. Then wake_valid_i=1, wake_i=1 two cycles later -> 4 beats forwarded, busy_o high 6 cycles, frame_cnt=1, wake_cnt=1, wake_o high exactly WAKE_HOLD cycles.
- cfg_req_i and s_valid_i rise together in IDLE, cfg_req held 3 cycles -> cfg_gnt_o=1 for 3 cycles, s_ready_o=0. First beat accepted in the cycle cfg_req_i falls.
- cfg_req_i rises on beat 2 of a 5-beat frame -> cfg_gnt_o stays 0 until the cycle after wake_valid_i, then 1.
- No wake_valid_i after last, TIMEOUT_CYCLES=8 -> return to IDLE 8 cycles after the last beat; timeout_cnt=1, frame_cnt unchanged, wake_o=0.
- Two positive decisions WAKE_HOLD/2 apart (WAKE_HOLD=10) -> wake_o continuously high for 15 cycles; wake_cnt=2.
- rst_n_i asserted mid-STREAM with m_ready_i toggling -> all outputs 0 immediately. After release the FSM is in IDLE and the next beat starts a new frame.
